cache_mem_burst_adapter: RTL and testbench
==========================================

Name: cache_mem_burst_adapter

Overview:
- Memory-side stage directly downstream of the write-back cache controller.
- Accepts one line-level request (write-back of a dirty line, or fill of a missing line), performs it as LINE_WORDS sequential single-word accesses on a simple req/ack RAM port, then returns a one-cycle completion pulse.
- For fills, it also returns the assembled line data.
- Its completion pulse is the controller's mem_res_valid input.

Parameters:
ADDR_WIDTH, 32, byte address width
WORD_WIDTH, 32, RAM word width in bits (multiple of 8)
LINE_WORDS, 4, words per cache line (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
mem_req_valid  in  1  line request from cache controller
mem_req_wen  in  1  1 = write-back line, 0 = fill line
mem_req_addr  in  ADDR_WIDTH  line byte address
mem_req_wdata  in  LINE_WORDS*WORD_WIDTH  line to write; word i at bits [i*WORD_WIDTH +: WORD_WIDTH]
mem_res_valid  out  1  one-cycle completion pulse
mem_res_rdata  out  LINE_WORDS*WORD_WIDTH  filled line, same packing; valid when mem_res_valid=1
busy  out  1  request in progress (not IDLE)
ram_req  out  1  word access request
ram_we  out  1  word write enable
ram_addr  out  ADDR_WIDTH  word byte address
ram_wdata  out  WORD_WIDTH  word write data
ram_rdata  in  WORD_WIDTH  word read data, valid with ram_ack
ram_ack  in  1  word access done; may assert in same cycle as ram_req

Behaviour:
- Reset (rst=0, async): state=IDLE; word counter=0; latched addr/wen/wdata=0; mem_res_rdata=0. All outputs are 0: mem_res_valid, busy, ram_req, ram_we, ram_addr, ram_wdata. On release, IDLE on the next rising edge.
- States:
  - IDLE:
    - busy=0, ram_req=0.
    - If mem_req_valid=1 on an edge: latch mem_req_addr with its low log2(LINE_WORDS*WORD_WIDTH/8) bits forced to 0, latch mem_req_wen and mem_req_wdata, clear counter, go to XFER.
    - A fill clears the mem_res_rdata register on acceptance.
  - XFER:
    - busy=1, ram_req=1, ram_we=latched wen.
    - ram_addr = base + counter*(WORD_WIDTH/8).
    - ram_wdata = latched word[counter]; it is 0 for fills.
    - Outputs are driven from registers and are stable while waiting for ack.
    - ram_ack=0: hold.
    - ram_ack=1 on an edge:
      - For a fill, capture ram_rdata into mem_res_rdata word[counter].
      - If counter==LINE_WORDS-1, go to DONE. Otherwise counter+1 and stay in XFER.
      - The next word's ram_req follows with no idle gap.
  - DONE:
    - busy=1, ram_req=0, mem_res_valid=1 for exactly this cycle.
    - Next state is unconditionally IDLE.
- mem_req_valid is ignored in XFER and DONE. The controller re-asserts it in the completion cycle; that assertion must not start a new transfer.
- mem_res_rdata holds its value after DONE until the next fill is accepted. Write-backs leave it unchanged.
- Latency: with ram_ack tied high, request edge to mem_res_valid = LINE_WORDS+1 cycles. Each additional ack wait cycle adds 1.
- Counter width is log2(LINE_WORDS) and does not wrap within a request. Address increment is ADDR_WIDTH-bit modulo; no carry into the tag beyond ADDR_WIDTH.
- Reset asserted mid-XFER: ram_req drops immediately (async). Partial data is discarded, no mem_res_valid is produced, and the partially written line is the system's responsibility.
- Unknown state encodings: outputs 0, next state IDLE.

Test Plan:
- Fill, LINE_WORDS=4, addr=0x0000_1234, RAM model acks 2 cycles after each req with rdata=0xA0+index:
  - ram_addr sequence 0x1230, 0x1234, 0x1238, 0x123C.
  - ram_we=0 throughout.
  - One mem_res_valid pulse.
  - mem_res_rdata = {0xA3,0xA2,0xA1,0xA0}.
  - busy high from the cycle after acceptance through DONE.
- Write-back, addr=0x100, wdata words {0x44,0x33,0x22,0x11}, ram_ack tied 1:
  - Writes 0x11@0x100, 0x22@0x104, 0x33@0x108, 0x44@0x10C on consecutive cycles.
  - mem_res_valid exactly 5 cycles after the request edge.
  - mem_res_rdata unchanged.
- Controller-style sequence: write-back at 0x200, mem_req_valid re-asserted in the completion cycle, then a fill request the next cycle:
  - The completion-cycle assertion is ignored.
  - The fill starts from IDLE with ram_addr=0x200.
  - Exactly two mem_res_valid pulses total.
- mem_req_valid held high for the whole of a fill: no second transfer starts until IDLE. Each accepted request produces exactly one pulse.
- rst driven low asynchronously mid-clock during word 2 of a fill:
  - ram_req, busy and mem_res_valid go 0 at once.
  - After release, no pulse appears.
  - A new fill to 0x40 completes correctly.
- Unaligned addr 0xFFFF_FFFF with 32-bit address: base 0xFFFF_FFF0; addresses 0xFFFF_FFF0..0xFFFF_FFFC; no overflow beyond the line.

Source files
------------

// File: rtl/cache_mem_burst_adapter.sv
// Purpose : splits one cache-line request (fill or write-back) into LINE_WORDS
//           sequential single-word req/ack RAM accesses, then pulses completion.
// Latency : request edge to mem_res_valid sampled = LINE_WORDS+1 cycles with ram_ack
//           tied high; each ack wait cycle adds one.
// Backpres: ram_ack low holds the current word; mem_req_valid is ignored while busy.
// Ports   : clk/rst (async, active-low); mem_req_* line request in; mem_res_valid /
//           mem_res_rdata completion + fill line out; busy; ram_* single-word port.
module cache_mem_burst_adapter #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             mem_req_valid,
  input  logic                             mem_req_wen,
  input  logic [ADDR_WIDTH-1:0]            mem_req_addr,
  input  logic [LINE_WORDS*WORD_WIDTH-1:0] mem_req_wdata,
  output logic                             mem_res_valid,
  output logic [LINE_WORDS*WORD_WIDTH-1:0] mem_res_rdata,
  output logic                             busy,
  output logic                             ram_req,
  output logic                             ram_we,
  output logic [ADDR_WIDTH-1:0]            ram_addr,
  output logic [WORD_WIDTH-1:0]            ram_wdata,
  input  logic [WORD_WIDTH-1:0]            ram_rdata,
  input  logic                             ram_ack
);

  localparam int LINE_W     = LINE_WORDS * WORD_WIDTH;
  localparam int CNT_W      = $clog2(LINE_WORDS);
  localparam int WORD_BYTES = WORD_WIDTH / 8;
  localparam int OFF_W      = $clog2(LINE_WORDS * WORD_BYTES);
  // Clears the byte offset within the line.
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~((ADDR_WIDTH'(1) << OFF_W) - ADDR_WIDTH'(1));

  // Encoding 2'd3 is unused; it decodes to all-zero outputs and returns to IDLE.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  wen_q, wen_d;
  logic [LINE_W-1:0]     wdata_q, wdata_d;
  logic [LINE_W-1:0]     rdata_q, rdata_d;

  logic                  last_word;
  logic                  accept;
  logic                  word_done;
  logic [WORD_WIDTH-1:0] cur_wword;

  assign last_word = (cnt_q == CNT_W'(LINE_WORDS - 1));
  assign accept    = (state_q == S_IDLE) && mem_req_valid;
  assign word_done = (state_q == S_XFER) && ram_ack;

  // Current write word, selected with constant slices only.
  always_comb begin
    cur_wword = '0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        cur_wword = wdata_q[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = mem_req_valid ? S_XFER : S_IDLE;
      S_XFER:  state_d = (ram_ack && last_word) ? S_DONE : S_XFER;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // All outputs decode from registered state, so they stay stable while ack is low.
  always_comb begin
    busy          = 1'b0;
    ram_req       = 1'b0;
    ram_we        = 1'b0;
    ram_addr      = '0;
    ram_wdata     = '0;
    mem_res_valid = 1'b0;
    case (state_q)
      S_XFER: begin
        busy      = 1'b1;
        ram_req   = 1'b1;
        ram_we    = wen_q;
        ram_addr  = base_q + ADDR_WIDTH'(cnt_q) * ADDR_WIDTH'(WORD_BYTES);
        ram_wdata = wen_q ? cur_wword : '0;
      end
      S_DONE: begin
        busy          = 1'b1;
        mem_res_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_res_rdata = rdata_q;

  // ---------------- Datapath next-state ----------------
  always_comb begin
    cnt_d   = cnt_q;
    base_d  = base_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (accept) begin
      cnt_d   = '0;
      base_d  = mem_req_addr & LINE_MASK;
      wen_d   = mem_req_wen;
      wdata_d = mem_req_wdata;
      // The fill result is rebuilt from scratch; write-backs keep the last fill line.
      if (!mem_req_wen) begin
        rdata_d = '0;
      end
    end else if (word_done) begin
      if (!wen_q) begin
        for (int i = 0; i < LINE_WORDS; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            rdata_d[i*WORD_WIDTH +: WORD_WIDTH] = ram_rdata;
          end
        end
      end
      // Counter stops at the last word; DONE follows instead of a wrap.
      if (!last_word) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      base_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_cache_mem_burst_adapter.sv
module tb_cache_mem_burst_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_req_valid, mem_req_wen;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_wdata;
  logic         mem_res_valid;
  logic [127:0] mem_res_rdata;
  logic         busy, ram_req, ram_we;
  logic [31:0]  ram_addr, ram_wdata, ram_rdata;
  logic         ram_ack;

  always #5 clk = ~clk;

  cache_mem_burst_adapter #(.ADDR_WIDTH(32), .WORD_WIDTH(32), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_wen(mem_req_wen),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_res_valid(mem_res_valid), .mem_res_rdata(mem_res_rdata),
    .busy(busy), .ram_req(ram_req), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack)
  );

  // RAM model: ack either tied high or after ack_dly wait cycles; read data 0xA0+word index.
  logic ack_tie;
  int   ack_dly;
  int   wcnt;
  assign ram_ack   = ram_req && (ack_tie || (wcnt >= ack_dly));
  assign ram_rdata = 32'hA0 + {30'd0, ram_addr[3:2]};
  always @(posedge clk) begin
    if (ram_req && !ram_ack) wcnt <= wcnt + 1;
    else                     wcnt <= 0;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } acc_t;
  typedef struct { logic [127:0] rdata; int cyc; } res_t;
  acc_t exp_acc[$];
  res_t exp_res[$];

  int n_vec = 0;
  int n_err = 0;
  int n_pulse = 0;

  localparam logic [127:0] LINE_A = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  localparam logic [127:0] WB_100 = {32'h44, 32'h33, 32'h22, 32'h11};
  localparam logic [127:0] WB_200 = {32'h5555_0004, 32'h5555_0003, 32'h5555_0002, 32'h5555_0001};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a word access or a completion.
  always @(negedge clk) begin
    if (rst) begin
      chk("busy_vs_state", busy, ram_req | mem_res_valid);
      if (ram_req && ram_ack) begin
        if (exp_acc.size() == 0) begin
          chk("unexpected_access", {ram_we, ram_addr, ram_wdata}, '0);
        end else begin
          acc_t a;
          a = exp_acc.pop_front();
          chk("ram_access", {ram_we, ram_addr, ram_wdata}, {a.we, a.addr, a.wdata});
        end
      end
      if (mem_res_valid) begin
        n_pulse++;
        if (exp_res.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          res_t r;
          r = exp_res.pop_front();
          chk("res_rdata", mem_res_rdata, r.rdata);
          if (r.cyc >= 0) chk("res_latency", cyc, r.cyc);
        end
      end
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 200 && busy; k++) @(negedge clk);
    chk("idle_timeout", busy, 0);
  endtask

  task automatic push_line(input logic wen, input logic [31:0] base, input logic [127:0] wd,
                           input logic [127:0] exp_rdata);
    for (int i = 0; i < 4; i++) begin
      acc_t a;
      a.we    = wen;
      a.addr  = base + 32'(4 * i);
      a.wdata = wen ? wd[i*32 +: 32] : 32'h0;
      exp_acc.push_back(a);
    end
    begin
      res_t r;
      r.rdata = exp_rdata;
      r.cyc   = -1;
      exp_res.push_back(r);
    end
  endtask

  // One-cycle request; timed=1 also checks the pulse lands LINE_WORDS cycles after acceptance.
  task automatic issue(input logic wen, input logic [31:0] addr, input logic [127:0] wd,
                       input logic [31:0] exp_base, input logic [127:0] exp_rdata, input bit timed);
    wait_idle();
    push_line(wen, exp_base, wd, exp_rdata);
    @(negedge clk);
    mem_req_valid = 1'b1; mem_req_wen = wen; mem_req_addr = addr; mem_req_wdata = wd;
    @(negedge clk);
    mem_req_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    if (timed) exp_res[exp_res.size()-1].cyc = cyc + 4;
  endtask

  task automatic wait_pulse(input string name);
    bit seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      seen = mem_res_valid;
    end
    chk(name, seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    rst = 1'b0; mem_req_valid = 0; mem_req_wen = 0; mem_req_addr = 0; mem_req_wdata = 0;
    ack_tie = 1'b1; ack_dly = 0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {mem_res_valid, busy, ram_req, ram_we, ram_addr, ram_wdata}, '0);
    chk("rst_rdata", mem_res_rdata, '0);
    #1 rst = 1'b1;

    // Fill 0x1234 with 2-cycle ack delay.
    ack_tie = 1'b0; ack_dly = 2;
    issue(1'b0, 32'h0000_1234, '0, 32'h0000_1230, LINE_A, 1'b0);
    wait_idle();
    chk("fill_rdata_hold", mem_res_rdata, LINE_A);

    // Write-back 0x100, ack tied high: latency and rdata untouched.
    ack_tie = 1'b1;
    issue(1'b1, 32'h0000_0100, WB_100, 32'h0000_0100, LINE_A, 1'b1);
    wait_idle();

    // Controller-style: valid re-asserted in the completion cycle, fill the cycle after.
    p0 = n_pulse;
    issue(1'b1, 32'h0000_0200, WB_200, 32'h0000_0200, LINE_A, 1'b1);
    wait_pulse("wb200_pulse");
    push_line(1'b0, 32'h0000_0200, '0, LINE_A);
    mem_req_valid = 1'b1; mem_req_wen = 1'b0; mem_req_addr = 32'h0000_0200; mem_req_wdata = '0;
    @(negedge clk);
    @(negedge clk);
    mem_req_valid = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    chk("ctrl_seq_pulses", n_pulse - p0, 2);

    // Valid held high through a whole fill: exactly one transfer.
    p0 = n_pulse;
    push_line(1'b0, 32'h0000_0300, '0, LINE_A);
    @(negedge clk);
    mem_req_valid = 1'b1; mem_req_wen = 1'b0; mem_req_addr = 32'h0000_0300;
    wait_pulse("held_pulse");
    mem_req_valid = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    chk("held_pulses", n_pulse - p0, 1);

    // Async reset mid-clock during word 2 of a fill.
    ack_tie = 1'b0; ack_dly = 2;
    issue(1'b0, 32'h0000_0080, '0, 32'h0000_0080, LINE_A, 1'b0);
    begin
      bit at_w2 = 0;
      for (int k = 0; k < 50 && !at_w2; k++) begin
        @(negedge clk);
        at_w2 = ram_req && (ram_addr == 32'h0000_0088);
      end
      chk("reached_word2", at_w2, 1);
    end
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_outputs", {ram_req, busy, mem_res_valid}, 3'b000);
    chk("rst_mid_rdata", mem_res_rdata, '0);
    exp_acc.delete();
    exp_res.delete();
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    p0 = n_pulse;
    repeat (8) @(negedge clk);
    chk("no_pulse_after_rst", n_pulse - p0, 0);
    issue(1'b0, 32'h0000_0040, '0, 32'h0000_0040, LINE_A, 1'b0);
    wait_idle();

    // Unaligned top-of-space address.
    ack_tie = 1'b1;
    issue(1'b0, 32'hFFFF_FFFF, '0, 32'hFFFF_FFF0, LINE_A, 1'b1);
    wait_idle();

    repeat (3) @(negedge clk);
    chk("acc_queue_drained", exp_acc.size(), 0);
    chk("res_queue_drained", exp_res.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
